adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester request accept; one-hot or zero.
REQ-006 req_a  input  2N  operand A; bits [N-1:0] requester 0, [2N-1:N] requester 1.
REQ-007 req_b  input  2N  operand B, same packing as req_a.
REQ-008 req_cin  input  2  carry-in per requester.
REQ-009 rsp_valid  output  2  result valid; one-hot or zero, bit = owning requester.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_sum  output  N  registered sum, shared by both requesters.
REQ-012 rsp_flags  output  3  registered {N,C,V} flags; bit2=N, bit1=C, bit0=V.
REQ-013 rsp_zero  output  1  present only when ADDER_ARB_ZERO_FLAG_EN is defined (REQ-030).

Function
REQ-014 Block SHALL time-share exactly one instance of the team N-bit ripple adder between two requesters.
REQ-015 FSM states SHALL be IDLE, CALC, RESP.
REQ-016 IDLE: if any req_valid, grant one requester, assert its req_ready combinationally that cycle, latch its A/B/cin and grant index, go to CALC; else stay in IDLE.
REQ-017 req_ready SHALL be zero in CALC and RESP.
REQ-018 Single valid requester SHALL be granted; both valid -> grant the requester not granted last (round-robin via last_grant register).
REQ-019 last_grant SHALL update only on a grant.
REQ-020 CALC: adder driven from latched operands; sum and flags registered into rsp_sum/rsp_flags; go to RESP; lasts exactly one cycle.
REQ-021 Flags: N = sum[N-1]; C = carry out of bit N-1; V = carry out of bit N-1 XOR carry into bit N-1.
REQ-022 RESP: rsp_valid[grant]=1; hold rsp_sum/rsp_flags stable; on rsp_ready[grant]=1 go to IDLE the next cycle.
REQ-023 rsp_ready on the non-owning bit SHALL be ignored.
REQ-024 Latency: request accepted cycle t -> rsp_valid high from cycle t+2; max throughput one op per 3 cycles.
REQ-025 Requests presented during CALC/RESP SHALL be held off (not dropped); requester must hold valid and operands until ready.
REQ-026 rsp_sum/rsp_flags SHALL retain last result in IDLE; only rsp_valid marks validity.

Reset
REQ-027 reset SHALL force state=IDLE, rsp_valid=0, req_ready=0, rsp_sum=0, rsp_flags=0, rsp_zero=0.
REQ-028 reset SHALL set last_grant=1 so requester 0 wins the first tie.
REQ-029 reset asserted in CALC or RESP SHALL abort the operation; no rsp_valid for it; reset dominates all other inputs.

Configuration
REQ-030 Macro ADDER_ARB_ZERO_FLAG_EN: when defined, rsp_zero port exists, registered in CALC as 1 iff sum==0, held with rsp_sum; when undefined, port and logic absent, all other behaviour identical.

Verification (N=32)
REQ-031 Req0 A=0x7FFFFFFF B=1 cin=0, rsp_ready=1 -> ready0 at t, rsp_valid=01 at t+2, sum=0x80000000, flags=3'b101.
REQ-032 Req1 A=0xFFFFFFFF B=1 cin=0 -> rsp_valid=10, sum=0, flags=3'b010; with macro, rsp_zero=1.
REQ-033 After reset both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; first grant requester 0; new grant every 3 cycles.
REQ-034 Req0 A=5 B=3 cin=1, rsp_ready=0 for 4 cycles -> rsp_valid=01, sum=9 held stable 4 cycles; req1 held off (ready1=0) until cycle after acceptance.
REQ-035 reset pulsed one cycle while in CALC -> no rsp_valid; next cycle IDLE; pending req0 granted first.
REQ-036 A=0x80000000 B=0x80000000 cin=0 -> sum=0, flags=3'b011.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one N-bit ripple adder; registered sum and {N,C,V} flags.
// Optional rsp_zero result flag is built when ADDER_ARB_ZERO_FLAG_EN is defined.

module adder_arbiter_ripple #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         c_msb_in
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out    = c[N];
    assign c_msb_in = c[N-1];
endmodule

module adder_arbiter #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    input  logic [1:0]     req_cin,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [N-1:0]   rsp_sum,
    output logic [2:0]     rsp_flags,
`ifdef ADDER_ARB_ZERO_FLAG_EN
    output logic           rsp_zero,
`endif
    output logic [1:0]     dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a requester holds valid and operands stable until it sees its ready bit.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         grant_q, grant_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic         cin_q, cin_d;
    logic [N-1:0] sum_q, sum_d;
    logic [2:0]   flags_q, flags_d;
    logic         pick;
    logic [N-1:0] add_sum;
    logic         add_cout, add_cmsb;
`ifdef ADDER_ARB_ZERO_FLAG_EN
    logic         zero_q, zero_d;
`endif

    adder_arbiter_ripple #(.N(N)) u_adder (
        .a        (a_q),
        .b        (b_q),
        .cin      (cin_q),
        .sum      (add_sum),
        .c_out    (add_cout),
        .c_msb_in (add_cmsb)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        sum_d        = sum_q;
        flags_d      = flags_q;
`ifdef ADDER_ARB_ZERO_FLAG_EN
        zero_d       = zero_q;
`endif
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        // On a tie the requester that lost last time wins.
        pick = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[pick] = 1'b1;
                    grant_d         = pick;
                    last_grant_d    = pick;
                    a_d             = pick ? req_a[N +: N] : req_a[0 +: N];
                    b_d             = pick ? req_b[N +: N] : req_b[0 +: N];
                    cin_d           = req_cin[pick];
                    state_d         = CALC;
                end
            end
            CALC: begin
                sum_d   = add_sum;
                flags_d = {add_sum[N-1], add_cout, add_cout ^ add_cmsb};
`ifdef ADDER_ARB_ZERO_FLAG_EN
                zero_d  = (add_sum == '0);
`endif
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset overrides the handshake outputs in the same cycle it is asserted.
        if (reset) begin
            req_ready = 2'b00;
            rsp_valid = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            sum_q        <= '0;
            flags_q      <= '0;
`ifdef ADDER_ARB_ZERO_FLAG_EN
            zero_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            sum_q        <= sum_d;
            flags_q      <= flags_d;
`ifdef ADDER_ARB_ZERO_FLAG_EN
            zero_q       <= zero_d;
`endif
        end
    end

    assign rsp_sum   = sum_q;
    assign rsp_flags = flags_q;
`ifdef ADDER_ARB_ZERO_FLAG_EN
    assign rsp_zero  = zero_q;
`endif
    assign dbg_state = state_q;
endmodule
